// File: rtl/freq_sweep_ctrl_if.sv
// Bus bundle between the sweep sequencer and its controller / divider.
// The slave side is the sequencer; the master side drives config, start/stop and div_tc.
interface freq_sweep_ctrl_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned DW = 8
) ();
    logic          start;
    logic          stop;
    logic [W-1:0]  start_val;
    logic [W-1:0]  end_val;
    logic [W-1:0]  step;
    logic [DW-1:0] dwell;
    logic          div_tc;
    logic [W-1:0]  div_val;
    logic          div_preset;
    logic [7:0]    step_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, start_val, end_val, step, dwell, div_tc,
        input  div_val, div_preset, step_idx, busy, done
    );

    modport slave (
        input  start, stop, start_val, end_val, step, dwell, div_tc,
        output div_val, div_preset, step_idx, busy, done
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep sequencer: steps a presettable divider's load value from
// start_val toward end_val, dwelling a fixed number of terminal counts per step.
module freq_sweep_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    freq_sweep_ctrl_if.slave bus
);
    localparam int unsigned IW = 8;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT, S_FIN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_div_val;
    logic [W-1:0]   r_end;
    logic [W-1:0]   r_step;
    logic [DW-1:0]  r_dwell_m1;
    logic [DW-1:0]  r_dwell_cnt;
    logic [IW-1:0]  r_step_idx;
    logic           r_up;
    logic           r_preset;
    logic           r_busy;
    logic           r_done;

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_next_val;
    logic           w_last_tc;
    logic [W-1:0]   w_div_val_d;
    logic [IW-1:0]  w_step_idx_d;
    logic [DW-1:0]  w_dwell_cnt_d;
    logic           w_cfg_en;

    assign w_last_tc = bus.div_tc && (r_dwell_cnt == r_dwell_m1);
    assign w_sum     = {1'b0, r_div_val} + {1'b0, r_step};
    assign w_diff    = {1'b0, r_div_val} - {1'b0, r_step};

    // Next value with overshoot or wrap clamped to end_val
    always_comb begin
        if (r_up) begin
            w_next_val = (w_sum[W] || (w_sum[W-1:0] > r_end)) ? r_end : w_sum[W-1:0];
        end else begin
            w_next_val = (w_diff[W] || (w_diff[W-1:0] < r_end)) ? r_end : w_diff[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // stop takes priority over every transition out of an active state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start && !bus.stop) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = bus.stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_tc) begin
                    w_state_nxt = ((r_div_val == r_end) || (r_step == '0)) ? S_FIN : S_NEXT;
                end
            end
            S_NEXT:  w_state_nxt = bus.stop ? S_IDLE : S_LOAD;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_div_val_d   = r_div_val;
        w_step_idx_d  = r_step_idx;
        w_dwell_cnt_d = r_dwell_cnt;
        w_cfg_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_state_nxt == S_LOAD) begin
                    w_div_val_d  = bus.start_val;
                    w_step_idx_d = '0;
                    w_cfg_en     = 1'b1;
                end
            end
            S_LOAD: w_dwell_cnt_d = '0;
            S_RUN: begin
                if (bus.div_tc) w_dwell_cnt_d = r_dwell_cnt + DW'(1);
            end
            S_NEXT: begin
                if (w_state_nxt == S_LOAD) begin
                    w_div_val_d  = w_next_val;
                    w_step_idx_d = (r_step_idx == '1) ? r_step_idx : r_step_idx + IW'(1);
                end
            end
            default: ;
        endcase
    end

    // Flags are registered from the next state so they track the state Moore-style
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_val   <= '0;
            r_end       <= '0;
            r_step      <= '0;
            r_dwell_m1  <= '0;
            r_dwell_cnt <= '0;
            r_step_idx  <= '0;
            r_up        <= 1'b0;
            r_preset    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_div_val   <= w_div_val_d;
            r_step_idx  <= w_step_idx_d;
            r_dwell_cnt <= w_dwell_cnt_d;
            r_preset    <= (w_state_nxt == S_LOAD);
            r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) || (w_state_nxt == S_NEXT);
            r_done      <= (w_state_nxt == S_FIN);
            if (w_cfg_en) begin
                r_end      <= bus.end_val;
                r_step     <= bus.step;
                r_dwell_m1 <= (bus.dwell == '0) ? '0 : bus.dwell - DW'(1);
                r_up       <= (bus.end_val >= bus.start_val);
            end
        end
    end

    assign bus.div_val    = r_div_val;
    assign bus.div_preset = r_preset;
    assign bus.step_idx   = r_step_idx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
